// File: rtl/mux_scan_capture.sv
// Scans a six-input one-hot mux A..F and latches each returned byte into its own register.
// Define SCAN_CONTINUOUS_EN to chain passes back-to-back after the first start.
module mux_scan_capture #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [5:0]       sel,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] A_q,
   output logic [WIDTH-1:0] B_q,
   output logic [WIDTH-1:0] C_q,
   output logic [WIDTH-1:0] D_q,
   output logic [WIDTH-1:0] E_q,
   output logic [WIDTH-1:0] F_q,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
   localparam logic [5:0] SEL_FIRST = 6'b100000;
   localparam logic [2:0] K_LAST    = 3'd5;

   state_t           state_q, state_d;
   logic [2:0]       k_q, k_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [5:0]       sel_q, sel_d;
   logic [WIDTH-1:0] cap_q [6];
   logic [WIDTH-1:0] cap_d [6];

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      cap_d   = cap_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               k_d     = '0;
               cnt_d   = '0;
               sel_d   = SEL_FIRST;
            end
         end
         SCAN: begin
            if (cnt_q == SETTLE_C) begin
               cap_d[k_q] = Y;
               cnt_d      = '0;
               if (k_q == K_LAST) begin
                  state_d = DONE;
                  k_d     = '0;
                  sel_d   = '0;
               end else begin
                  k_d   = k_q + 3'd1;
                  sel_d = sel_q >> 1;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
`ifdef SCAN_CONTINUOUS_EN
            state_d = SCAN;
            k_d     = '0;
            cnt_d   = '0;
            sel_d   = SEL_FIRST;
`else
            state_d = IDLE;
`endif
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
            cnt_d   = '0;
            sel_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         for (int unsigned i = 0; i < 6; i++) begin
            cap_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         cap_q   <= cap_d;
      end
   end

   assign sel  = sel_q;
   assign busy = (state_q == SCAN);
   assign done = (state_q == DONE);
   assign A_q  = cap_q[0];
   assign B_q  = cap_q[1];
   assign C_q  = cap_q[2];
   assign D_q  = cap_q[3];
   assign E_q  = cap_q[4];
   assign F_q  = cap_q[5];

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: SETTLE=1 instance plus a SETTLE=3 instance,
// each fed by a registered one-hot mux model.
module tb_mux_scan_capture;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, start3;
   logic [5:0] sel, sel3;
   logic [7:0] Y, Y3;
   logic [7:0] A_q, B_q, C_q, D_q, E_q, F_q;
   logic [7:0] A3, B3, C3, D3, E3, F3;
   logic       busy, done, busy3, done3;
   logic [7:0] src [6];
   logic [7:0] src3 [6];
   logic [7:0] q [6];
   logic [7:0] q3 [6];
   logic [7:0] prev [6];

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mux_scan_capture #(.WIDTH(8), .SETTLE(1)) dut (
      .clk(clk), .reset(reset), .start(start), .sel(sel), .Y(Y),
      .A_q(A_q), .B_q(B_q), .C_q(C_q), .D_q(D_q), .E_q(E_q), .F_q(F_q),
      .busy(busy), .done(done)
   );

   mux_scan_capture #(.WIDTH(8), .SETTLE(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .sel(sel3), .Y(Y3),
      .A_q(A3), .B_q(B3), .C_q(C3), .D_q(D3), .E_q(E3), .F_q(F3),
      .busy(busy3), .done(done3)
   );

   // Registered one-hot mux models; output 0 when nothing is selected.
   always @(posedge clk) begin
      case (sel)
         6'b100000: Y <= src[0];
         6'b010000: Y <= src[1];
         6'b001000: Y <= src[2];
         6'b000100: Y <= src[3];
         6'b000010: Y <= src[4];
         6'b000001: Y <= src[5];
         default:   Y <= 8'h00;
      endcase
      case (sel3)
         6'b100000: Y3 <= src3[0];
         6'b010000: Y3 <= src3[1];
         6'b001000: Y3 <= src3[2];
         6'b000100: Y3 <= src3[3];
         6'b000010: Y3 <= src3[4];
         6'b000001: Y3 <= src3[5];
         default:   Y3 <= 8'h00;
      endcase
   end

   assign q[0] = A_q;  assign q[1] = B_q;  assign q[2] = C_q;
   assign q[3] = D_q;  assign q[4] = E_q;  assign q[5] = F_q;
   assign q3[0] = A3;  assign q3[1] = B3;  assign q3[2] = C3;
   assign q3[3] = D3;  assign q3[4] = E3;  assign q3[5] = F3;

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start3 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         vectors++;
         if ({sel, busy, done, sel3, busy3, done3} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_idle_ctrl cyc %0d: got %h want 0000", i,
                     {sel, busy, done, sel3, busy3, done3});
         end
         vectors++;
         if ({A_q, B_q, C_q, D_q, E_q, F_q, A3, B3, C3, D3, E3, F3} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_idle_regs cyc %0d: got %h want 0", i,
                     {A_q, B_q, C_q, D_q, E_q, F_q, A3, B3, C3, D3, E3, F3});
         end
      end
   endtask

   task automatic test_scan_pass();
      logic [7:0] exp;
      for (int k = 0; k < 6; k++) prev[k] = q[k];
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int j = 0; j <= 13; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         exp = (j < 12) ? {6'b100000 >> (j / 2), 1'b1, 1'b0}
                        : {6'b000000, 1'b0, (j == 12)};
         vectors++;
         if ({sel, busy, done} !== exp) begin
            miscompares++;
            $display("FAIL pass_seq j=%0d: got sel/busy/done %b want %b", j, {sel, busy, done}, exp);
         end
         if (j >= 2 && j <= 12 && (j % 2) == 0) begin
            vectors++;
            if (q[j/2-1] !== src[j/2-1]) begin
               miscompares++;
               $display("FAIL pass_capture slot %0d: got %h want %h", j/2-1, q[j/2-1], src[j/2-1]);
            end
         end
         if (j <= 11 && (j % 2) == 1) begin
            vectors++;
            if (q[(j-1)/2] !== prev[(j-1)/2]) begin
               miscompares++;
               $display("FAIL pass_early slot %0d: got %h want %h", (j-1)/2, q[(j-1)/2], prev[(j-1)/2]);
            end
         end
      end
      vectors++;
      if ({A_q, B_q, C_q, D_q, E_q, F_q} !== 48'h112233445566) begin
         miscompares++;
         $display("FAIL pass_fields: got %h want 112233445566", {A_q, B_q, C_q, D_q, E_q, F_q});
      end
   endtask

   task automatic test_hold_start();
      int dones = 0;
      int done_at = -1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      for (int j = 1; j <= 14; j++) begin
         @(posedge clk); #1;
         if (done) dones++;
         if (j == 13) begin
            vectors++;
            if ({sel, busy, done} !== 8'h00) begin
               miscompares++;
               $display("FAIL hold_idle_gap: got %b want 00000000", {sel, busy, done});
            end
            vectors++;
            if (dones !== 1) begin
               miscompares++;
               $display("FAIL hold_done_count: got %0d want 1", dones);
            end
         end
      end
      start = 1'b0;
      vectors++;
      if ({sel, busy, done} !== 8'b10000010) begin
         miscompares++;
         $display("FAIL hold_restart: got %b want 10000010", {sel, busy, done});
      end
      for (int j = 15; j <= 30; j++) begin
         @(posedge clk); #1;
         if (done && done_at < 0) done_at = j;
      end
      vectors++;
      if (done_at !== 26) begin
         miscompares++;
         $display("FAIL hold_second_done: got cycle %0d want 26", done_at);
      end
      vectors++;
      if ({sel, busy, done} !== 8'h00) begin
         miscompares++;
         $display("FAIL hold_final_idle: got %b want 00000000", {sel, busy, done});
      end
   endtask

   task automatic test_src_change();
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int j = 1; j <= 13; j++) begin
         @(posedge clk); #1;
         if (j == 6) src[2] = 8'hC3;
      end
      vectors++;
      if ({A_q, B_q, C_q, D_q, E_q, F_q} !== 48'h112233445566) begin
         miscompares++;
         $display("FAIL chg_first_pass: got %h want 112233445566", {A_q, B_q, C_q, D_q, E_q, F_q});
      end
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      vectors++;
      if ({A_q, B_q, C_q, D_q, E_q, F_q} !== 48'h1122C3445566) begin
         miscompares++;
         $display("FAIL chg_second_pass: got %h want 1122C3445566", {A_q, B_q, C_q, D_q, E_q, F_q});
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      vectors++;
      if ({sel, busy} !== 7'b0001001) begin
         miscompares++;
         $display("FAIL mid_slot_d: got %b want 0001001", {sel, busy});
      end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if ({sel, busy, done} !== 8'h00) begin
         miscompares++;
         $display("FAIL mid_async_ctrl: got %b want 00000000", {sel, busy, done});
      end
      vectors++;
      if ({A_q, B_q, C_q, D_q, E_q, F_q} !== 48'h0) begin
         miscompares++;
         $display("FAIL mid_async_regs: got %h want 0", {A_q, B_q, C_q, D_q, E_q, F_q});
      end
      @(negedge clk) reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vectors++;
         if ({sel, busy, done} !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_no_resume cyc %0d: got %b want 00000000", i, {sel, busy, done});
         end
      end
   endtask

   task automatic test_settle3();
      logic [7:0] exp;
      @(negedge clk) start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      for (int j = 0; j <= 25; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         exp = (j < 24) ? {6'b100000 >> (j / 4), 1'b1, 1'b0}
                        : {6'b000000, 1'b0, (j == 24)};
         vectors++;
         if ({sel3, busy3, done3} !== exp) begin
            miscompares++;
            $display("FAIL s3_seq j=%0d: got %b want %b", j, {sel3, busy3, done3}, exp);
         end
         if (j >= 4 && j <= 24 && (j % 4) == 0) begin
            vectors++;
            if (q3[j/4-1] !== src3[j/4-1]) begin
               miscompares++;
               $display("FAIL s3_capture slot %0d: got %h want %h", j/4-1, q3[j/4-1], src3[j/4-1]);
            end
         end
         if (j >= 3 && j <= 23 && (j % 4) == 3) begin
            vectors++;
            if (q3[j/4] !== 8'h00) begin
               miscompares++;
               $display("FAIL s3_early slot %0d: got %h want 00", j/4, q3[j/4]);
            end
         end
      end
   endtask

   task automatic test_continuous();
      logic [7:0] exp;
      int p;
      int dones = 0;
      @(negedge clk) start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      for (int j = 0; j <= 75; j++) begin
         if (j > 0) begin
            @(posedge clk); #1;
         end
         p = j % 25;
         exp = (p < 24) ? {6'b100000 >> (p / 4), 1'b1, 1'b0} : {6'b000000, 1'b0, 1'b1};
         if (done3) dones++;
         vectors++;
         if ({sel3, busy3, done3} !== exp) begin
            miscompares++;
            $display("FAIL cont_seq j=%0d: got %b want %b", j, {sel3, busy3, done3}, exp);
         end
         vectors++;
         if ($countones(sel3) > 1) begin
            miscompares++;
            $display("FAIL cont_onehot j=%0d: got %b want at most one bit", j, sel3);
         end
      end
      vectors++;
      if (dones !== 3) begin
         miscompares++;
         $display("FAIL cont_done_count: got %0d want 3", dones);
      end
      vectors++;
      if ({A3, B3, C3, D3, E3, F3} !== 48'h010204081020) begin
         miscompares++;
         $display("FAIL cont_fields: got %h want 010204081020", {A3, B3, C3, D3, E3, F3});
      end
   endtask

   initial begin
      src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
      src[3] = 8'h44; src[4] = 8'h55; src[5] = 8'h66;
      src3[0] = 8'h01; src3[1] = 8'h02; src3[2] = 8'h04;
      src3[3] = 8'h08; src3[4] = 8'h10; src3[5] = 8'h20;
      test_reset();
`ifdef SCAN_CONTINUOUS_EN
      test_continuous();
`else
      test_scan_pass();
      test_hold_start();
      test_src_change();
      test_reset_mid();
      test_settle3();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
